// File: rtl/load_store_unit.sv
// Load/store unit between the RV32 datapath and a word-wide synchronous data RAM.
// Sub-word stores are read-modify-write; sub-word loads are extracted and extended.
module load_store_unit #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  CLK,
   input  logic                  RESET_N,
   input  logic                  REQ_VALID,
   output logic                  REQ_READY,
   input  logic                  REQ_WE,
   input  logic [2:0]            REQ_FUNCT3,
   input  logic [ADDR_WIDTH+1:0] REQ_ADDR,
   input  logic [31:0]           REQ_WDATA,
   output logic                  RSP_VALID,
   output logic                  RSP_ERR,
   output logic [31:0]           RSP_RDATA,
   output logic [ADDR_WIDTH-1:0] MEM_ADDR,
   output logic                  MEM_WE,
   output logic [31:0]           MEM_D,
   input  logic [31:0]           MEM_Q
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_CAP,
      S_WR,
      S_RESP
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH+1:0] addr_q, addr_d;
   logic [2:0]            funct3_q, funct3_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  we_q, we_d;
   logic [31:0]           word_q, word_d;
   logic                  err_q, err_d;
   logic [31:0]           rdata_q, rdata_d;

   logic                  req_err;
   logic [7:0]            load_byte;
   logic [15:0]           load_half;
   logic [31:0]           load_data;
   logic [31:0]           merged;

   // Illegal funct3 or misalignment, decoded from the live request in IDLE.
   always_comb begin
      req_err = 1'b1;
      case (REQ_FUNCT3)
         3'b000:  req_err = 1'b0;
         3'b001:  req_err = REQ_ADDR[0];
         3'b010:  req_err = |REQ_ADDR[1:0];
         3'b100:  req_err = REQ_WE;
         3'b101:  req_err = REQ_WE | REQ_ADDR[0];
         default: req_err = 1'b1;
      endcase
   end

   always_comb begin
      load_byte = MEM_Q[7:0];
      for (int i = 0; i < 4; i++) begin
         if (addr_q[1:0] == 2'(i)) begin
            load_byte = MEM_Q[8*i +: 8];
         end
      end
      load_half = addr_q[1] ? MEM_Q[31:16] : MEM_Q[15:0];
      case (funct3_q[1:0])
         2'b00:   load_data = {{24{~funct3_q[2] & load_byte[7]}}, load_byte};
         2'b01:   load_data = {{16{~funct3_q[2] & load_half[15]}}, load_half};
         default: load_data = MEM_Q;
      endcase
   end

   // Store data merged into the captured word; SW replaces the whole word.
   always_comb begin
      merged = word_q;
      case (funct3_q[1:0])
         2'b00: begin
            for (int i = 0; i < 4; i++) begin
               if (addr_q[1:0] == 2'(i)) begin
                  merged[8*i +: 8] = wdata_q[7:0];
               end
            end
         end
         2'b01: begin
            if (addr_q[1]) begin
               merged[31:16] = wdata_q[15:0];
            end else begin
               merged[15:0] = wdata_q[15:0];
            end
         end
         default: merged = wdata_q;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      funct3_d = funct3_q;
      wdata_d  = wdata_q;
      we_d     = we_q;
      word_d   = word_q;
      err_d    = 1'b0;
      rdata_d  = 32'd0;
      case (state_q)
         S_IDLE: begin
            if (REQ_VALID) begin
               addr_d   = REQ_ADDR;
               funct3_d = REQ_FUNCT3;
               wdata_d  = REQ_WDATA;
               we_d     = REQ_WE;
               if (req_err) begin
                  state_d = S_RESP;
                  err_d   = 1'b1;
               end else if (!REQ_WE || REQ_FUNCT3[1:0] != 2'b10) begin
                  state_d = S_RD;
               end else begin
                  state_d = S_WR;
               end
            end
         end
         S_RD: begin
            state_d = S_CAP;
         end
         S_CAP: begin
            word_d = MEM_Q;
            if (!we_q) begin
               state_d = S_RESP;
               rdata_d = load_data;
            end else begin
               state_d = S_WR;
            end
         end
         S_WR: begin
            state_d = S_RESP;
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         funct3_q <= 3'd0;
         wdata_q  <= 32'd0;
         we_q     <= 1'b0;
         word_q   <= 32'd0;
         err_q    <= 1'b0;
         rdata_q  <= 32'd0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         funct3_q <= funct3_d;
         wdata_q  <= wdata_d;
         we_q     <= we_d;
         word_q   <= word_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
      end
   end

   // Write enable comes from the state register alone, so reset kills it at once.
   assign REQ_READY = (state_q == S_IDLE);
   assign RSP_VALID = (state_q == S_RESP);
   assign RSP_ERR   = err_q;
   assign RSP_RDATA = rdata_q;
   assign MEM_ADDR  = addr_q[ADDR_WIDTH+1:2];
   assign MEM_WE    = (state_q == S_WR);
   assign MEM_D     = (state_q == S_WR) ? merged : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word RAM, reference memory model checked every cycle,
// and directed requests with hand-computed results.
module tb_load_store_unit;

   logic        CLK;
   logic        RESET_N;
   logic        REQ_VALID;
   logic        REQ_READY;
   logic        REQ_WE;
   logic [2:0]  REQ_FUNCT3;
   logic [11:0] REQ_ADDR;
   logic [31:0] REQ_WDATA;
   logic        RSP_VALID;
   logic        RSP_ERR;
   logic [31:0] RSP_RDATA;
   logic [9:0]  MEM_ADDR;
   logic        MEM_WE;
   logic [31:0] MEM_D;
   logic [31:0] MEM_Q;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int acc_count = 0;

   logic [31:0] ram [0:1023];
   logic [31:0] ref_mem [0:1023];

   load_store_unit #(.ADDR_WIDTH(10)) dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
      .REQ_FUNCT3(REQ_FUNCT3), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
      .RSP_VALID(RSP_VALID), .RSP_ERR(RSP_ERR), .RSP_RDATA(RSP_RDATA),
      .MEM_ADDR(MEM_ADDR), .MEM_WE(MEM_WE), .MEM_D(MEM_D), .MEM_Q(MEM_Q)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   always @(posedge CLK) cyc <= cyc + 1;

   always @(posedge CLK) begin
      if (MEM_WE) ram[MEM_ADDR] <= MEM_D;
      MEM_Q <= ram[MEM_ADDR];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%08h expected=%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: expected response/write schedule per accepted request.
   int          m_acc = -100;
   int          m_rsp = -100;
   int          m_wr  = -100;
   logic        m_err;
   logic [31:0] m_rdata;
   logic [31:0] m_d;
   logic [9:0]  m_wa;

   always @(negedge CLK) begin
      if (!RESET_N) begin
         chk("rst_mem_we", 32'(MEM_WE), 32'd0);
         chk("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
         chk("rst_req_ready", 32'(REQ_READY), 32'd1);
         m_acc = -100;
         m_rsp = -100;
         m_wr  = -100;
      end else begin
         automatic logic busy = (cyc > m_acc) && (cyc <= m_rsp);
         chk("req_ready", 32'(REQ_READY), 32'(!busy));
         chk("rsp_valid", 32'(RSP_VALID), 32'(cyc == m_rsp));
         chk("rsp_err", 32'(RSP_ERR), (cyc == m_rsp) ? 32'(m_err) : 32'd0);
         chk("rsp_rdata", RSP_RDATA, (cyc == m_rsp) ? m_rdata : 32'd0);
         chk("mem_we", 32'(MEM_WE), 32'(cyc == m_wr));
         if (cyc == m_wr) begin
            chk("mem_addr", 32'(MEM_ADDR), 32'(m_wa));
            chk("mem_d", MEM_D, m_d);
            ref_mem[m_wa] = m_d;
         end
         if (REQ_VALID && REQ_READY) begin
            automatic int          f3    = int'(REQ_FUNCT3);
            automatic int          addr  = int'(REQ_ADDR);
            automatic int          nb    = 1 << (f3 % 4);
            automatic int          sh    = 8 * (addr % 4);
            automatic logic [63:0] mask  = (64'd1 << (8 * nb)) - 64'd1;
            automatic logic [63:0] old   = {32'd0, ref_mem[addr / 4]};
            automatic logic [63:0] v;
            automatic logic        legal;
            legal = REQ_WE ? (f3 <= 2) : (f3 inside {0, 1, 2, 4, 5});
            acc_count++;
            m_acc   = cyc;
            m_wa    = 10'(addr / 4);
            m_rdata = 32'd0;
            m_wr    = -100;
            m_err   = !legal || (addr % nb != 0);
            if (m_err) begin
               m_rsp = cyc + 1;
            end else if (!REQ_WE) begin
               v = (old >> sh) & mask;
               if (f3 < 4 && nb < 4 && v >= (mask + 64'd1) / 2) v = v - (mask + 64'd1);
               m_rdata = v[31:0];
               m_rsp   = cyc + 3;
            end else begin
               v   = (old & ~(mask << sh)) | (({32'd0, REQ_WDATA} & mask) << sh);
               m_d = v[31:0];
               m_rsp = (nb == 4) ? cyc + 2 : cyc + 4;
               m_wr  = m_rsp - 1;
            end
         end
      end
   end

   // One directed transaction with literal expectations; latencies relative to accept.
   task automatic run(input string name, input logic we, input logic [2:0] f3,
                      input logic [11:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                      input int exp_we_lat, input logic [31:0] exp_md);
      int acc = -1;
      int lat = -1;
      int we_lat = -1;
      int we_cnt = 0;
      logic [31:0] md = 32'd0;
      logic [31:0] rd = 32'd0;
      logic        er = 1'b0;
      @(posedge CLK);
      #1;
      REQ_WE = we; REQ_FUNCT3 = f3; REQ_ADDR = addr; REQ_WDATA = wdata; REQ_VALID = 1'b1;
      for (int i = 0; i < 20 && acc < 0; i++) begin
         @(negedge CLK);
         if (REQ_READY) acc = cyc;
      end
      @(posedge CLK);
      #1;
      REQ_VALID = 1'b0;
      if (acc < 0) begin
         chk({name, ".accept_timeout"}, 32'd0, 32'd1);
      end else begin
         for (int i = 0; i < 10 && lat < 0; i++) begin
            @(negedge CLK);
            if (MEM_WE) begin we_lat = cyc - acc; md = MEM_D; we_cnt++; end
            if (RSP_VALID) begin lat = cyc - acc; rd = RSP_RDATA; er = RSP_ERR; end
         end
         chk({name, ".lat"}, 32'(lat), 32'(exp_lat));
         chk({name, ".rdata"}, rd, exp_rdata);
         chk({name, ".err"}, 32'(er), 32'(exp_err));
         chk({name, ".we_cycle"}, 32'(we_lat), 32'(exp_we_lat));
         chk({name, ".we_count"}, 32'(we_cnt), (exp_we_lat >= 0) ? 32'd1 : 32'd0);
         if (exp_we_lat >= 0) chk({name, ".mem_d"}, md, exp_md);
         $display("txn %-6s we=%0b f3=%03b addr=%03h wdata=%08h -> lat=%0d err=%0b rdata=%08h",
                  name, we, f3, addr, wdata, lat, er, rd);
      end
   endtask

   task automatic hold(input string name, input logic we, input logic [2:0] f3,
                       input logic [11:0] addr, input logic [31:0] wdata,
                       input int ncyc, input int exp_acc);
      int a0;
      @(posedge CLK);
      #1;
      REQ_WE = we; REQ_FUNCT3 = f3; REQ_ADDR = addr; REQ_WDATA = wdata; REQ_VALID = 1'b1;
      a0 = acc_count;
      repeat (ncyc) @(negedge CLK);
      @(posedge CLK);
      #1;
      REQ_VALID = 1'b0;
      chk({name, ".accepts"}, 32'(acc_count - a0), 32'(exp_acc));
      $display("txn %-6s held %0d cycles -> %0d accepts", name, ncyc, acc_count - a0);
   endtask

   initial begin
      #500000;
      errors++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1);
   end

   initial begin
      int acc;
      int rsp_seen;
      RESET_N = 1'b0; REQ_VALID = 1'b0; REQ_WE = 1'b0;
      REQ_FUNCT3 = 3'd0; REQ_ADDR = 12'd0; REQ_WDATA = 32'd0;
      for (int i = 0; i < 1024; i++) begin ram[i] = 32'd0; ref_mem[i] = 32'd0; end
      ram[4] = 32'h804020F1; ref_mem[4] = 32'h804020F1;
      ram[8] = 32'h11223344; ref_mem[8] = 32'h11223344;
      repeat (3) @(posedge CLK);
      #2;
      chk("reset.req_ready", 32'(REQ_READY), 32'd1);
      chk("reset.rsp_valid", 32'(RSP_VALID), 32'd0);
      chk("reset.rsp_err", 32'(RSP_ERR), 32'd0);
      chk("reset.rsp_rdata", RSP_RDATA, 32'd0);
      chk("reset.mem_we", 32'(MEM_WE), 32'd0);
      chk("reset.mem_addr", 32'(MEM_ADDR), 32'd0);
      chk("reset.mem_d", MEM_D, 32'd0);
      RESET_N = 1'b1;

      run("lw",    1'b0, 3'b010, 12'h010, 32'd0, 32'h804020F1, 1'b0, 3, -1, 32'd0);
      run("lb3",   1'b0, 3'b000, 12'h013, 32'd0, 32'hFFFFFF80, 1'b0, 3, -1, 32'd0);
      run("lbu3",  1'b0, 3'b100, 12'h013, 32'd0, 32'h00000080, 1'b0, 3, -1, 32'd0);
      run("lh2",   1'b0, 3'b001, 12'h012, 32'd0, 32'hFFFF8040, 1'b0, 3, -1, 32'd0);
      run("lhu2",  1'b0, 3'b101, 12'h012, 32'd0, 32'h00008040, 1'b0, 3, -1, 32'd0);
      run("lb0",   1'b0, 3'b000, 12'h010, 32'd0, 32'hFFFFFFF1, 1'b0, 3, -1, 32'd0);
      run("sb1",   1'b1, 3'b000, 12'h011, 32'h123456AB, 32'd0, 1'b0, 4, 3, 32'h8040ABF1);
      run("lw_sb", 1'b0, 3'b010, 12'h010, 32'd0, 32'h8040ABF1, 1'b0, 3, -1, 32'd0);
      run("sw",    1'b1, 3'b010, 12'h014, 32'hDEADBEEF, 32'd0, 1'b0, 2, 1, 32'hDEADBEEF);
      run("sh2",   1'b1, 3'b001, 12'h016, 32'h0000CAFE, 32'd0, 1'b0, 4, 3, 32'hCAFEBEEF);
      run("lw_sh", 1'b0, 3'b010, 12'h014, 32'd0, 32'hCAFEBEEF, 1'b0, 3, -1, 32'd0);
      run("e_lw",  1'b0, 3'b010, 12'h012, 32'd0, 32'd0, 1'b1, 1, -1, 32'd0);
      run("e_sh",  1'b1, 3'b001, 12'h011, 32'hFFFFFFFF, 32'd0, 1'b1, 1, -1, 32'd0);
      run("e_f3",  1'b0, 3'b011, 12'h010, 32'd0, 32'd0, 1'b1, 1, -1, 32'd0);
      run("e_sf3", 1'b1, 3'b100, 12'h010, 32'hFFFFFFFF, 32'd0, 1'b1, 1, -1, 32'd0);
      run("lw_chk",1'b0, 3'b010, 12'h010, 32'd0, 32'h8040ABF1, 1'b0, 3, -1, 32'd0);
      run("lhu0",  1'b0, 3'b101, 12'h014, 32'd0, 32'h0000BEEF, 1'b0, 3, -1, 32'd0);

      hold("b2b_lw", 1'b0, 3'b010, 12'h010, 32'd0, 16, 4);
      hold("b2b_sw", 1'b1, 3'b010, 12'h030, 32'h55AA00FF, 12, 4);
      run("lw_b2b",1'b0, 3'b010, 12'h030, 32'd0, 32'h55AA00FF, 1'b0, 3, -1, 32'd0);

      // SB aborted by reset during its write cycle.
      @(posedge CLK);
      #1;
      REQ_WE = 1'b1; REQ_FUNCT3 = 3'b000; REQ_ADDR = 12'h021; REQ_WDATA = 32'h000000EE;
      REQ_VALID = 1'b1;
      acc = -1;
      for (int i = 0; i < 20 && acc < 0; i++) begin
         @(negedge CLK);
         if (REQ_READY) acc = cyc;
      end
      @(posedge CLK);
      #1;
      REQ_VALID = 1'b0;
      @(posedge CLK);
      @(posedge CLK);
      #2;
      chk("abort.we_before", 32'(MEM_WE), 32'd1);
      RESET_N = 1'b0;
      #1;
      chk("abort.we_async_drop", 32'(MEM_WE), 32'd0);
      chk("abort.ready_in_reset", 32'(REQ_READY), 32'd1);
      @(negedge CLK);
      @(posedge CLK);
      #2;
      RESET_N = 1'b1;
      rsp_seen = 0;
      repeat (8) begin
         @(negedge CLK);
         if (RSP_VALID) rsp_seen++;
      end
      chk("abort.no_rsp", 32'(rsp_seen), 32'd0);
      chk("abort.ready_after", 32'(REQ_READY), 32'd1);
      chk("abort.word_kept", ram[8], 32'h11223344);
      $display("txn abort  sb addr=021 reset in write cycle -> rsp=%0d word8=%08h", rsp_seen, ram[8]);
      run("lw_rst",1'b0, 3'b010, 12'h020, 32'd0, 32'h11223344, 1'b0, 3, -1, 32'd0);

      for (int w = 0; w < 16; w++) chk($sformatf("ram_word%0d", w), ram[w], ref_mem[w]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
